alt_vipvfr131_prc_write_master: RTL and testbench



---
 rtl/alt_vipvfr131_prc_write_master_if.sv | 24 ++
 rtl/alt_vipvfr131_prc_write_master.sv | 175 +++++++++++++++++
 tb/tb_alt_vipvfr131_prc_write_master.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alt_vipvfr131_prc_write_master_if.sv
// Avalon-MM write-master bus bundle for the frame-buffer write path.
// The master drives the command/data side; the interconnect answers with waitrequest.
interface alt_vipvfr131_prc_write_master_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int BURST_WIDTH = 6
) ();
    logic [ADDR_WIDTH-1:0]  av_address;
    logic [BURST_WIDTH-1:0] av_burstcount;
    logic [DATA_WIDTH-1:0]  av_writedata;
    logic                   av_write;
    logic                   av_read;
    logic                   av_waitrequest;

    modport master (
        output av_address, av_burstcount, av_writedata, av_write, av_read,
        input  av_waitrequest
    );

    modport slave (
        input  av_address, av_burstcount, av_writedata, av_write, av_read,
        output av_waitrequest
    );
endinterface

// File: rtl/alt_vipvfr131_prc_write_master.sv
// Bursting Avalon-MM write master: packs narrow pixel words LSB-first into memory words,
// buffers them in a FIFO and writes them out as fixed-size bursts over a commanded length.
module alt_vipvfr131_prc_write_master #(
    parameter int ADDR_WIDTH                     = 32,
    parameter int DATA_WIDTH                     = 64,
    parameter int UNPACKED_WIDTH                 = 16,
    parameter int MAX_BURST_LENGTH_REQUIREDWIDTH = 11,
    parameter int BURST_WIDTH                    = 6,
    parameter int WRITE_FIFO_DEPTH               = 16,
    parameter int WRITE_TARGET_BURST_SIZE        = 8
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      ena,
    output logic                                      stall,
    input  logic                                      cmd,
    input  logic [ADDR_WIDTH-1:0]                     cmd_addr,
    input  logic [MAX_BURST_LENGTH_REQUIREDWIDTH-1:0] cmd_length_of_burst,
    input  logic                                      write,
    input  logic [UNPACKED_WIDTH-1:0]                 write_data,
    input  logic                                      flush_partial_word,
    output logic                                      busy,
    alt_vipvfr131_prc_write_master_if.master          av
);
    localparam int N       = DATA_WIDTH / UNPACKED_WIDTH;
    localparam int SLOT_W  = (N > 1) ? $clog2(N) : 1;
    localparam int FIFO_AW = $clog2(WRITE_FIFO_DEPTH);
    localparam int LW      = MAX_BURST_LENGTH_REQUIREDWIDTH;
    localparam int BYTES   = DATA_WIDTH / 8;

    localparam logic [SLOT_W-1:0]      LAST_SLOT  = SLOT_W'(N - 1);
    localparam logic [BURST_WIDTH-1:0] TARGET_LEN = BURST_WIDTH'(WRITE_TARGET_BURST_SIZE);
    localparam logic [FIFO_AW:0]       FULL_COUNT = (FIFO_AW + 1)'(WRITE_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_DATA, BURST} state_t;

    state_t                  state, state_next;
    logic [SLOT_W-1:0]       slot;
    logic [DATA_WIDTH-1:0]   pack_word, merged_word;
    logic                    push_needed, push, pop, accept, cmd_load, fifo_full;
    logic [DATA_WIDTH-1:0]   fifo_mem [WRITE_FIFO_DEPTH];
    logic [FIFO_AW-1:0]      wr_ptr, rd_ptr;
    logic [FIFO_AW:0]        fifo_count;
    logic                    cmd_active, load_len, start_burst, last_beat;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [LW-1:0]           remaining, remaining_after;
    logic [BURST_WIDTH-1:0]  burst_len, beats_left;

    function automatic logic [BURST_WIDTH-1:0] clip_len(input logic [LW-1:0] words);
        if (words >= LW'(WRITE_TARGET_BURST_SIZE)) return TARGET_LEN;
        return BURST_WIDTH'(words);
    endfunction

    // NOTE: every always_comb output gets its default first so no path can infer a latch.
    always_comb begin
        merged_word = pack_word;
        if (write) merged_word[slot*UNPACKED_WIDTH +: UNPACKED_WIDTH] = write_data;
    end

    // A flush only pushes when it has something to pad; a write into the last slot pushes anyway.
    assign push_needed = write ? ((slot == LAST_SLOT) || flush_partial_word)
                               : (flush_partial_word && (slot != '0));
    assign fifo_full   = (fifo_count == FULL_COUNT);
    assign stall       = (cmd && cmd_active) ||
                         ((write || flush_partial_word) && push_needed && fifo_full);
    assign accept      = ena && !stall;
    assign push        = accept && push_needed;
    assign cmd_load    = accept && cmd;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            slot      <= '0;
            pack_word <= '0;
        end else if (push) begin
            slot      <= '0;
            pack_word <= '0;
        end else if (accept && write) begin
            slot      <= slot + SLOT_W'(1);
            pack_word <= merged_word;
        end
    end

    // NOTE: the storage array is not reset; the output mux below hides stale contents when empty.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= merged_word;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (FIFO_AW + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (FIFO_AW + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign remaining_after = remaining - LW'(burst_len);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        load_len    = 1'b0;
        start_burst = 1'b0;
        pop         = 1'b0;
        last_beat   = 1'b0;
        av.av_write = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_active) begin
                    load_len   = 1'b1;
                    state_next = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (32'(fifo_count) >= 32'(burst_len)) begin
                    start_burst = 1'b1;
                    state_next  = BURST;
                end
            end
            BURST: begin
                av.av_write = 1'b1;
                pop         = !av.av_waitrequest;
                if (pop && (beats_left == BURST_WIDTH'(1))) begin
                    last_beat  = 1'b1;
                    state_next = (remaining_after == '0) ? IDLE : WAIT_DATA;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr       <= '0;
            remaining  <= '0;
            cmd_active <= 1'b0;
            burst_len  <= '0;
            beats_left <= '0;
        end else begin
            if (cmd_load) begin
                addr       <= cmd_addr;
                remaining  <= cmd_length_of_burst;
                cmd_active <= (cmd_length_of_burst != '0);
            end
            if (load_len) burst_len <= clip_len(remaining);
            if (start_burst)  beats_left <= burst_len;
            else if (pop)     beats_left <= beats_left - BURST_WIDTH'(1);
            // Address and length advance only once the whole burst has been accepted.
            if (last_beat) begin
                addr      <= addr + ADDR_WIDTH'(burst_len) * ADDR_WIDTH'(BYTES);
                remaining <= remaining_after;
                if (remaining_after == '0) cmd_active <= 1'b0;
                else                       burst_len  <= clip_len(remaining_after);
            end
        end
    end

    assign busy             = cmd_active || (fifo_count != '0);
    assign av.av_address    = addr;
    assign av.av_burstcount = burst_len;
    assign av.av_writedata  = (fifo_count != '0) ? fifo_mem[rd_ptr] : '0;
    assign av.av_read       = 1'b0;
endmodule

// File: tb/tb_alt_vipvfr131_prc_write_master.sv
// Directed bench for the bursting write master (N=4 pixels per 64-bit word).
// Accepted Avalon beats are logged at the falling edge and compared with hand-derived values.
module tb_alt_vipvfr131_prc_write_master;
    logic        clk = 1'b0;
    logic        reset;
    logic        ena;
    logic        stall;
    logic        cmd;
    logic [31:0] cmd_addr;
    logic [10:0] cmd_length_of_burst;
    logic        write;
    logic [15:0] write_data;
    logic        flush_partial_word;
    logic        busy;
    int          wr_mode;
    int          n_checks = 0;
    int          n_errors = 0;

    logic [63:0] bq_data[$];
    logic [31:0] bq_addr[$];
    logic [5:0]  bq_bc[$];

    alt_vipvfr131_prc_write_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .BURST_WIDTH(6)) av_if ();

    alt_vipvfr131_prc_write_master dut (
        .clock               (clk),
        .reset               (reset),
        .ena                 (ena),
        .stall               (stall),
        .cmd                 (cmd),
        .cmd_addr            (cmd_addr),
        .cmd_length_of_burst (cmd_length_of_burst),
        .write               (write),
        .write_data          (write_data),
        .flush_partial_word  (flush_partial_word),
        .busy                (busy),
        .av                  (av_if.master)
    );

    always #5 clk = ~clk;

    // 0: waitrequest low, 1: random, 2: held high
    initial begin
        av_if.av_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (wr_mode)
                1:       av_if.av_waitrequest = 1'($urandom_range(0, 1));
                2:       av_if.av_waitrequest = 1'b1;
                default: av_if.av_waitrequest = 1'b0;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && av_if.av_write && !av_if.av_waitrequest) begin
                bq_data.push_back(av_if.av_writedata);
                bq_addr.push_back(av_if.av_address);
                bq_bc.push_back(av_if.av_burstcount);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input logic [15:0] b);
        return {b + 16'd3, b + 16'd2, b + 16'd1, b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic c, input logic [31:0] a, input logic [10:0] l,
                         input logic w, input logic [15:0] d, input logic f);
        int guard = 0;
        cmd = c; cmd_addr = a; cmd_length_of_burst = l;
        write = w; write_data = d; flush_partial_word = f;
        #1;
        while (stall && guard < 300) begin
            step();
            guard++;
        end
        if (guard >= 300) check("offer_timeout", 64'(stall), 64'h0);
        step();
        cmd = 1'b0; write = 1'b0; flush_partial_word = 1'b0;
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic [10:0] l);
        offer(1'b1, a, l, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic send_write(input logic [15:0] d);
        offer(1'b0, 32'h0, 11'h0, 1'b1, d, 1'b0);
    endtask

    task automatic clear_log();
        bq_data.delete();
        bq_addr.delete();
        bq_bc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1; ena = 1'b1; cmd = 1'b0; cmd_addr = '0; cmd_length_of_burst = '0;
        write = 1'b0; write_data = '0; flush_partial_word = 1'b0; wr_mode = 0;
        repeat (2) step();
        reset = 1'b0;
        step();
        clear_log();
    endtask

    task automatic wait_beats(input string tag, input int n);
        int guard = 0;
        while (bq_data.size() < n && guard < 600) begin
            step();
            guard++;
        end
        repeat (4) step();
        check(tag, 64'(bq_data.size()), 64'(n));
    endtask

    task automatic wait_idle(input string tag);
        int guard = 0;
        while (busy && guard < 600) begin
            step();
            guard++;
        end
        check(tag, 64'(busy), 64'h0);
    endtask

    task automatic expect_beat(input string tag, input int j, input logic [31:0] a,
                               input logic [5:0] bc, input logic [63:0] d);
        if (j < bq_data.size()) begin
            check({tag, "_addr"}, 64'(bq_addr[j]), 64'(a));
            check({tag, "_bc"},   64'(bq_bc[j]),   64'(bc));
            check({tag, "_data"}, bq_data[j],      d);
        end else begin
            check({tag, "_missing"}, 64'(bq_data.size()), 64'(j + 1));
        end
    endtask

    initial begin
        wr_mode = 0;
        do_reset();
        check("rst_stall",      64'(stall),                64'h0);
        check("rst_busy",       64'(busy),                 64'h0);
        check("rst_av_write",   64'(av_if.av_write),       64'h0);
        check("rst_av_read",    64'(av_if.av_read),        64'h0);
        check("rst_av_address", 64'(av_if.av_address),     64'h0);
        check("rst_av_bc",      64'(av_if.av_burstcount),  64'h0);
        check("rst_av_wdata",   av_if.av_writedata,        64'h0);

        // Single 8-beat burst
        send_cmd(32'h1000, 11'd8);
        for (int i = 0; i < 32; i++) send_write(16'(i + 1));
        wait_beats("t1_count", 8);
        expect_beat("t1_first", 0, 32'h1000, 6'd8, 64'h0004_0003_0002_0001);
        for (int j = 1; j < 8; j++) expect_beat("t1_beat", j, 32'h1000, 6'd8, pack4(16'(4 * j + 1)));
        wait_idle("t1_idle");
        check("t1_av_read", 64'(av_if.av_read), 64'h0);

        // Length 20 split into 8, 8, 4
        clear_log();
        send_cmd(32'h1000, 11'd20);
        for (int i = 0; i < 80; i++) send_write(16'(i + 1));
        wait_beats("t2_count", 20);
        for (int j = 0; j < 20; j++)
            expect_beat("t2_beat", j, 32'h1000 + 32'(j / 8) * 32'h40,
                        (j < 16) ? 6'd8 : 6'd4, pack4(16'(4 * j + 1)));
        wait_idle("t2_idle");

        // Flush behaviour and ena gating
        clear_log();
        offer(1'b0, 32'h0, 11'h0, 1'b0, 16'h0, 1'b1);
        check("t3_flush_empty", 64'(busy), 64'h0);
        ena = 1'b0; write = 1'b1; write_data = 16'h55; flush_partial_word = 1'b1;
        step();
        write = 1'b0; flush_partial_word = 1'b0; ena = 1'b1;
        step();
        check("t3_ena_low", 64'(busy), 64'h0);
        send_write(16'h000A);
        send_write(16'h000B);
        send_write(16'h000C);
        offer(1'b0, 32'h0, 11'h0, 1'b0, 16'h0, 1'b1);
        send_cmd(32'h2000, 11'd1);
        wait_beats("t3_count", 1);
        expect_beat("t3_flush", 0, 32'h2000, 6'd1, 64'h0000_000C_000B_000A);
        wait_idle("t3_idle");

        // Write filling the last slot together with a flush pushes one word only
        clear_log();
        send_write(16'h0001);
        send_write(16'h0002);
        send_write(16'h0003);
        offer(1'b0, 32'h0, 11'h0, 1'b1, 16'h0004, 1'b1);
        send_cmd(32'h2100, 11'd1);
        wait_beats("t3b_count", 1);
        expect_beat("t3b_full_flush", 0, 32'h2100, 6'd1, 64'h0004_0003_0002_0001);
        wait_idle("t3b_no_extra");

        // Random waitrequest
        clear_log();
        wr_mode = 1;
        send_cmd(32'h3000, 11'd8);
        for (int i = 0; i < 32; i++) send_write(16'(16'h100 + i));
        wait_beats("t4_count", 8);
        for (int j = 0; j < 8; j++) expect_beat("t4_beat", j, 32'h3000, 6'd8, pack4(16'(16'h100 + 4 * j)));
        wr_mode = 0;
        wait_idle("t4_idle");

        // FIFO full back-pressure
        clear_log();
        for (int i = 0; i < 67; i++) send_write(16'(16'h500 + i));
        write = 1'b1; write_data = 16'h543;
        #1;
        check("t5_stall_full", 64'(stall), 64'h1);
        write = 1'b0;
        #1;
        check("t5_stall_drop", 64'(stall), 64'h0);
        send_cmd(32'h6000, 11'd16);
        cmd = 1'b1; cmd_addr = 32'h9999; cmd_length_of_burst = 11'd3;
        #1;
        check("t5_cmd_stall", 64'(stall), 64'h1);
        cmd = 1'b0;
        send_write(16'h543);
        wait_beats("t5_count", 16);
        for (int j = 0; j < 16; j++)
            expect_beat("t5_beat", j, 32'h6000 + 32'(j / 8) * 32'h40, 6'd8, pack4(16'(16'h500 + 4 * j)));
        check("t5_retained", 64'(busy), 64'h1);
        clear_log();
        send_cmd(32'h7000, 11'd1);
        wait_beats("t5_tail_count", 1);
        expect_beat("t5_tail", 0, 32'h7000, 6'd1, pack4(16'h540));
        wait_idle("t5_idle");

        // Reset in the middle of a burst
        clear_log();
        wr_mode = 2;
        send_cmd(32'h4000, 11'd8);
        for (int i = 0; i < 32; i++) send_write(16'(16'h600 + i));
        send_write(16'h00EE);
        send_write(16'h00EF);
        begin
            int guard = 0;
            while (!av_if.av_write && guard < 100) begin
                step();
                guard++;
            end
            check("t6_burst_started", 64'(av_if.av_write), 64'h1);
        end
        wr_mode = 0;
        repeat (3) step();
        do_reset();
        check("t6_rst_busy",  64'(busy),           64'h0);
        check("t6_rst_write", 64'(av_if.av_write), 64'h0);
        check("t6_rst_wdata", av_if.av_writedata,  64'h0);
        send_cmd(32'h5000, 11'd2);
        for (int i = 0; i < 8; i++) send_write(16'(16'h700 + i));
        wait_beats("t6_count", 2);
        expect_beat("t6_beat0", 0, 32'h5000, 6'd2, pack4(16'h700));
        expect_beat("t6_beat1", 1, 32'h5000, 6'd2, pack4(16'h704));
        wait_idle("t6_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end
endmodule
